// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared constants for the integer register file and its pending-write scoreboard.
//   XLEN        default register width
//   REG_ADDR_W  default register index width (depth = 1 << REG_ADDR_W)
//   REG_ZERO    index of the hard-wired zero register
//   NUM_RD_DEF / NUM_WR_DEF / PEND_W_DEF  default port counts and counter width
package regfile_mp_scoreboard_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_ZERO   = 0;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;
    localparam int PEND_W_DEF = 2;

    // Width of a "how many write ports hit this register" count (0..nwr).
    function automatic int dec_width(input int nwr);
        return (nwr < 1) ? 1 : $clog2(nwr + 1);
    endfunction
endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// Bundle of register-file traffic: write ports, read ports, dispatch
// reservation handshake, flush and the scoreboard view.
//   master: the pipeline (drives writes, reads, issue, flush)
//   slave : the register file (returns read data, busy bits, iss_ready)
// Multi-port fields are flat-packed, port k at [k*W +: W].
interface regfile_mp_scoreboard_if
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_RD     = NUM_RD_DEF,
    parameter int NUM_WR     = NUM_WR_DEF
);
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0]            rd_zero;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic                         iss_valid;
    logic [ADDR_WIDTH-1:0]        iss_rd;
    logic                         iss_ready;
    logic                         flush;
    logic [(1<<ADDR_WIDTH)-1:0]   busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rd_zero, iss_valid, iss_rd, flush,
        input  rd_data, rd_busy, iss_ready, busy_vec
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rd_zero, iss_valid, iss_rd, flush,
        output rd_data, rd_busy, iss_ready, busy_vec
    );
endinterface

// File: rtl/regfile_mp_scoreboard_pend_ctr.sv
// regfile_pend_ctr: outstanding-write counter for one register.
//   clk, rst   clock, async active-low reset
//   inc        one reservation accepted for this register
//   dec        number of write ports hitting this register this cycle
//   flush      synchronous clear, wins over inc/dec
//   cnt        current outstanding-producer count
// Next value is cnt + inc - dec clamped to [0, max]: a write with nothing
// pending is legal and must not wrap.
module regfile_pend_ctr #(
    parameter int PEND_WIDTH = 2,
    parameter int DEC_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic [DEC_W-1:0]      dec,
    input  logic                  flush,
    output logic [PEND_WIDTH-1:0] cnt
);
    localparam int CW   = ((PEND_WIDTH > DEC_W) ? PEND_WIDTH : DEC_W) + 1;
    localparam int MAXV = (1 << PEND_WIDTH) - 1;

    logic [CW-1:0] up;
    logic [CW-1:0] nxt;

    always_comb begin
        up = CW'(cnt) + CW'(inc);
        if (up <= CW'(dec)) nxt = '0;
        else                nxt = up - CW'(dec);
        if (nxt > CW'(MAXV)) nxt = CW'(MAXV);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt <= '0;
        else if (flush) cnt <= '0;
        else            cnt <= PEND_WIDTH'(nxt);
    end
endmodule

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: multi-port integer register file with same-cycle
// write-to-read bypass and a per-register pending-write scoreboard.
//   clk   clock, all state on rising edge
//   rst   asynchronous active-low reset
//   bus   slave side of regfile_mp_scoreboard_if (writes, reads, issue
//         handshake, flush, busy_vec)
// Index 0 is hard-wired to zero and never becomes busy.
module regfile_mp_scoreboard
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_RD     = NUM_RD_DEF,
    parameter int NUM_WR     = NUM_WR_DEF,
    parameter int PEND_WIDTH = PEND_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_mp_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int DEC_W = dec_width(NUM_WR);
    localparam int CW    = ((PEND_WIDTH > DEC_W) ? PEND_WIDTH : DEC_W) + 1;
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    logic [DATA_WIDTH-1:0]            regs [DEPTH];
    logic [DEPTH-1:0][PEND_WIDTH-1:0] pend;
    logic [DEPTH-1:0][DEC_W-1:0]      dec;
    logic                             iss_fire;

    // Register storage: ascending port order so the highest port lands last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wr_en[k] && bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO))
                    regs[bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Per-register count of write ports retiring a producer this cycle.
    always_comb begin
        dec = '0;
        for (int r = 0; r < DEPTH; r++)
            for (int k = 0; k < NUM_WR; k++)
                if (bus.wr_en[k] && bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
                    dec[r] = dec[r] + DEC_W'(1);
    end

    // Read ports: stored value, overridden by the highest matching write
    // port (bypass), overridden by zero for x0 or rd_zero. Busy only if
    // producers remain after this cycle's writes retire.
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rv;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rv = regs[ra];
            for (int k = 0; k < NUM_WR; k++)
                if (bus.wr_en[k] && bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)
                    rv = bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            if (bus.rd_zero[i] || ra == ADDR_WIDTH'(REG_ZERO)) begin
                rv = '0;
            end else begin
                bus.rd_busy[i] = CW'(pend[ra]) > CW'(dec[ra]);
            end
            bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rv;
        end
    end

    // Registered pend only: a same-cycle write to iss_rd cannot open the gate.
    assign bus.iss_ready = (bus.iss_rd == ADDR_WIDTH'(REG_ZERO)) || (pend[bus.iss_rd] != PEND_MAX);
    assign iss_fire      = bus.iss_valid && bus.iss_ready;

    assign pend[0]         = '0;
    assign bus.busy_vec[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < DEPTH; r++) begin : g_pend
            regfile_pend_ctr #(
                .PEND_WIDTH (PEND_WIDTH),
                .DEC_W      (DEC_W)
            ) u_ctr (
                .clk   (clk),
                .rst   (rst),
                .inc   (iss_fire && bus.iss_rd == ADDR_WIDTH'(r)),
                .dec   (dec[r]),
                .flush (bus.flush),
                .cnt   (pend[r])
            );
            assign bus.busy_vec[r] = (pend[r] != '0);
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard: reset, bypass priority, zero
// rules, scoreboard saturation, last-producer bypass, flush and back-to-back
// writes. Expected values are hand-computed constants.
module tb_regfile_mp_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_mp_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .NUM_WR(2)) bus ();

    regfile_mp_scoreboard #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_RD (2), .NUM_WR (2), .PEND_WIDTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr   = '0;
        bus.rd_zero   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en[k]           = 1'b1;
        bus.wr_addr[k*AW +: AW] = a;
        bus.wr_data[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a, input logic z);
        bus.rd_addr[i*AW +: AW] = a;
        bus.rd_zero[i]          = z;
    endtask

    function automatic logic [DW-1:0] rdd(input int i);
        return bus.rd_data[i*DW +: DW];
    endfunction

    task automatic test_reset();
        idle();
        rst = 1'b0;
        set_rd(0, 5'd1, 1'b0);
        bus.iss_rd = 5'd1;
        #2;
        checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy_vec got %h exp %h", bus.busy_vec, 32'h0); end
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready got %b exp 1", bus.iss_ready); end
        checks++; if (rdd(0) !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rdd(0)); end
        #1 rst = 1'b1;
        tick();
        // Load state, then assert reset mid-cycle and expect immediate clear.
        set_wr(0, 5'd1, 32'h11);
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd2;
        tick();
        idle();
        set_rd(0, 5'd1, 1'b0);
        #1;
        checks++; if (rdd(0) !== 32'h11 || bus.busy_vec !== 32'h4) begin errors++; $display("FAIL reset_preload got data %h busy %h exp 11 / 4", rdd(0), bus.busy_vec); end
        #1 rst = 1'b0;
        #1;
        checks++; if (rdd(0) !== 32'h0 || bus.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_async got data %h busy %h exp 0 / 0", rdd(0), bus.busy_vec); end
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        idle();
        set_wr(0, 5'd5, 32'hAAAA);
        set_wr(1, 5'd5, 32'hBBBB);
        set_rd(0, 5'd5, 1'b0);
        #1;
        checks++; if (rdd(0) !== 32'hBBBB) begin errors++; $display("FAIL bypass_priority got %h exp BBBB", rdd(0)); end
        tick();
        idle();
        set_rd(0, 5'd5, 1'b0);
        #1;
        checks++; if (rdd(0) !== 32'hBBBB) begin errors++; $display("FAIL write_priority got %h exp BBBB", rdd(0)); end
        checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL write_no_underflow got %h exp 0", bus.busy_vec); end
    endtask

    task automatic test_zero();
        idle();
        set_wr(0, 5'd7, 32'h55);
        tick();
        idle();
        set_wr(0, 5'd0, 32'h1234);
        set_rd(0, 5'd0, 1'b0);
        set_rd(1, 5'd7, 1'b1);
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        #1;
        checks++; if (rdd(0) !== 32'h0) begin errors++; $display("FAIL zero_x0_bypass got %h exp 0", rdd(0)); end
        checks++; if (rdd(1) !== 32'h0) begin errors++; $display("FAIL zero_rd_zero got %h exp 0", rdd(1)); end
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL zero_iss_ready got %b exp 1", bus.iss_ready); end
        tick();
        idle();
        set_rd(0, 5'd0, 1'b0);
        set_rd(1, 5'd7, 1'b0);
        #1;
        checks++; if (rdd(0) !== 32'h0 || rdd(1) !== 32'h55) begin errors++; $display("FAIL zero_after got %h %h exp 0 55", rdd(0), rdd(1)); end
        checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL zero_busy_vec got %h exp 0", bus.busy_vec); end
    endtask

    task automatic test_saturation();
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL sat_accept%0d got %b exp 1", n, bus.iss_ready); end
            tick();
        end
        set_rd(0, 5'd3, 1'b0);
        #1;
        checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %b exp 0", bus.iss_ready); end
        checks++; if (bus.busy_vec !== 32'h8 || bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sat_busy got %h %b exp 8 1", bus.busy_vec, bus.rd_busy[0]); end
        tick();
        // Rejected issue held, one write to x3: ready stays low this cycle.
        set_wr(0, 5'd3, 32'h33);
        #1;
        checks++; if (bus.iss_ready !== 1'b0 || bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sat_no_comb got %b %b exp 0 1", bus.iss_ready, bus.rd_busy[0]); end
        tick();
        bus.wr_en = '0;
        #1;
        checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL sat_release got %b exp 1", bus.iss_ready); end
        bus.iss_valid = 1'b0;
        // pend[3]=2: drain with both ports in one cycle.
        set_wr(0, 5'd3, 32'h1); set_wr(1, 5'd3, 32'h2);
        tick();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL sat_drain got %h exp 0", bus.busy_vec); end
    endtask

    task automatic test_last_producer();
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        tick();
        idle();
        set_rd(0, 5'd9, 1'b0);
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL lp_busy got %b exp 1", bus.rd_busy[0]); end
        set_wr(1, 5'd9, 32'hCAFE);
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b0 || rdd(0) !== 32'hCAFE) begin errors++; $display("FAIL lp_bypass got %b %h exp 0 CAFE", bus.rd_busy[0], rdd(0)); end
        tick();
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        tick();
        set_wr(0, 5'd9, 32'hBEEF);
        tick();
        idle();
        set_rd(0, 5'd9, 1'b0);
        #1;
        checks++; if (bus.busy_vec !== 32'h200 || rdd(0) !== 32'hBEEF) begin errors++; $display("FAIL lp_net got %h %h exp 200 BEEF", bus.busy_vec, rdd(0)); end
        set_wr(0, 5'd9, 32'h9);
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL lp_exactly_one got %b exp 0", bus.rd_busy[0]); end
        tick();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL lp_clear got %h exp 0", bus.busy_vec); end
    endtask

    task automatic test_flush();
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
        tick();
        tick();
        bus.iss_rd = 5'd6;
        tick();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 32'h50) begin errors++; $display("FAIL flush_pre got %h exp 50", bus.busy_vec); end
        bus.flush = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
        set_wr(0, 5'd4, 32'h77);
        tick();
        idle();
        set_rd(0, 5'd4, 1'b0);
        #1;
        checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL flush_busy got %h exp 0", bus.busy_vec); end
        checks++; if (rdd(0) !== 32'h77) begin errors++; $display("FAIL flush_write got %h exp 77", rdd(0)); end
        set_wr(0, 5'd6, 32'h66);
        tick();
        idle();
        set_rd(1, 5'd6, 1'b0);
        #1;
        checks++; if (bus.busy_vec !== 32'h0 || rdd(1) !== 32'h66) begin errors++; $display("FAIL flush_no_underflow got %h %h exp 0 66", bus.busy_vec, rdd(1)); end
    endtask

    task automatic test_back_to_back();
        idle();
        set_wr(0, 5'd10, 32'h100);
        set_wr(1, 5'd11, 32'h200);
        tick();
        idle();
        set_wr(1, 5'd10, 32'h300);
        set_rd(0, 5'd10, 1'b0);
        set_rd(1, 5'd11, 1'b0);
        #1;
        checks++; if (rdd(0) !== 32'h300 || rdd(1) !== 32'h200) begin errors++; $display("FAIL b2b_bypass got %h %h exp 300 200", rdd(0), rdd(1)); end
        tick();
        idle();
        set_rd(0, 5'd10, 1'b0);
        set_rd(1, 5'd5, 1'b0);
        #1;
        checks++; if (rdd(0) !== 32'h300 || rdd(1) !== 32'hBBBB) begin errors++; $display("FAIL b2b_stored got %h %h exp 300 BBBB", rdd(0), rdd(1)); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_bypass();
        test_zero();
        test_saturation();
        test_last_producer();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
